scratch_mem_slave: RTL and testbench

SCRATCH_MEM_SLAVE -- requirements
Module: scratch_mem_slave

---
 rtl/scratch_mem_slave.sv | 210 +++++++++++++++++++++
 tb/tb_scratch_mem_slave.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scratch_mem_slave.sv
// Word-addressed scratch memory behind a waitrequest-style slave port.
// Each access stalls for WAIT_CYCLES cycles, then completes in a single ACK cycle.
module scratch_mem_slave #(
  parameter int unsigned ADDR_WORDS  = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic [3:0]  slave_byteenable,
  output logic [31:0] slave_readdata,
  output logic        slave_waitrequest,
  input  logic        err_clr,
  output logic        err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int unsigned IdxW     = $clog2(ADDR_WORDS);
  localparam logic [3:0]  WaitLoad = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q;
  logic            in_range_q;
  logic            is_write_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;
  logic [31:0]     rdata_q;
  logic            err_q;
  logic [15:0]     rd_cnt_q, wr_cnt_q;

  logic [31:0]     mem [ADDR_WORDS];

  logic            req;
  logic            capture;
  logic            abort;
  logic [IdxW-1:0] req_idx;
  logic            req_in_range;
  logic            err_set;
  logic            enter_ack;
  logic [IdxW-1:0] rd_idx;
  logic            rd_ok;
  logic            rd_is_write;
  logic            unused_addr_bits;

  assign req              = slave_read | slave_write;
  assign req_idx          = slave_address[IdxW+1:2];
  assign req_in_range     = ~|slave_address[31:IdxW+2];
  assign unused_addr_bits = ^slave_address[1:0];

  assign capture = (state_q == StIdle) && req;
  assign abort   = (state_q == StWait) && !req;

  // Protocol violations: both commands at once, out-of-range index, or a dropped request.
  assign err_set = (capture && ((slave_read && slave_write) || !req_in_range)) || abort;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          cnt_d = WaitLoad;
          if (WAIT_CYCLES == 1) begin
            state_d = StAck;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (!req) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          // ACK follows the cycle in which the counter decrements to zero.
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = StAck;
          end
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    slave_waitrequest = req && (state_q != StAck);
  end

  assign slave_readdata = rdata_q;
  assign err            = err_q;
  assign rd_count       = rd_cnt_q;
  assign wr_count       = wr_cnt_q;

  // ---------------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q      <= '0;
      in_range_q <= 1'b0;
      is_write_q <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
    end else if (capture) begin
      idx_q      <= req_idx;
      in_range_q <= req_in_range;
      is_write_q <= slave_write;
      wdata_q    <= slave_writedata;
      be_q       <= slave_byteenable;
    end
  end

  // ---------------------------------------------------------------------------
  // Read data: loaded on entry to ACK. With a single wait cycle ACK is entered
  // straight from IDLE, before the capture registers hold the request.
  // ---------------------------------------------------------------------------
  always_comb begin
    enter_ack = (state_d == StAck) && (state_q != StAck);
    if (state_q == StIdle) begin
      rd_idx      = req_idx;
      rd_ok       = req_in_range;
      rd_is_write = slave_write;
    end else begin
      rd_idx      = idx_q;
      rd_ok       = in_range_q;
      rd_is_write = is_write_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (enter_ack && !rd_is_write) begin
      rdata_q <= rd_ok ? mem[rd_idx] : 32'h0000_0000;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory array: not reset; writes commit at the edge closing the ACK cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if ((state_q == StAck) && is_write_q && in_range_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Completion counters and sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (state_q == StAck) begin
      if (is_write_q) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end else begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scratch_mem_slave.sv
// Randomized scoreboard bench for scratch_mem_slave against an array-based memory model.
module tb_scratch_mem_slave;

  localparam int unsigned Words = 256;
  localparam int unsigned Wc    = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] slave_address;
  logic        slave_read;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic [3:0]  slave_byteenable;
  logic [31:0] slave_readdata;
  logic        slave_waitrequest;
  logic        err_clr;
  logic        err;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  scratch_mem_slave #(
    .ADDR_WORDS  (Words),
    .WAIT_CYCLES (Wc)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .slave_address     (slave_address),
    .slave_read        (slave_read),
    .slave_write       (slave_write),
    .slave_writedata   (slave_writedata),
    .slave_byteenable  (slave_byteenable),
    .slave_readdata    (slave_readdata),
    .slave_waitrequest (slave_waitrequest),
    .err_clr           (err_clr),
    .err               (err),
    .rd_count          (rd_count),
    .wr_count          (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [Words];
  int          rd_exp;
  int          wr_exp;
  bit          err_exp;
  int          checks;
  int          errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every completed handshake is matched against the scoreboard.
  int lat;
  always @(negedge clk) begin
    if (!reset_n) begin
      lat = 0;
    end else if (slave_read || slave_write) begin
      lat++;
      if (!slave_waitrequest) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("latency", lat, Wc + 1);
          if (e.is_read) check("readdata", slave_readdata, e.data);
        end
        lat = 0;
      end
    end else begin
      lat = 0;
    end
  end

  task automatic idle(input int n);
    slave_read  = 1'b0;
    slave_write = 1'b0;
    err_clr     = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issues one access, updates the model, waits for the handshake; the request stays
  // asserted on return so the caller can chain a back-to-back access or go idle.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be, input bit clr);
    int unsigned widx;
    bit oor;
    bit done;
    exp_t e;
    widx = int'(addr[31:2]);
    oor  = widx >= Words;
    if (clr) err_exp = 1'b0;
    if (wr) begin
      if (!oor) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) ref_mem[widx][8*b +: 8] = data[8*b +: 8];
        end
      end
      wr_exp++;
      if (rd || oor) err_exp = 1'b1;
      e.is_read = 1'b0;
      e.data    = '0;
    end else begin
      rd_exp++;
      if (oor) err_exp = 1'b1;
      e.is_read = 1'b1;
      e.data    = oor ? 32'h0 : ref_mem[widx];
    end
    exp_q.push_back(e);
    slave_address    = addr;
    slave_read       = rd;
    slave_write      = wr;
    slave_writedata  = data;
    slave_byteenable = be;
    err_clr          = clr;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    done    = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (!slave_waitrequest) done = 1'b1;
    end
    if (!done) check("ack_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rd_exp = 0;
    wr_exp = 0;
    err_exp = 1'b0;
    reset_n          = 1'b0;
    slave_address    = '0;
    slave_read       = 1'b0;
    slave_write      = 1'b0;
    slave_writedata  = '0;
    slave_byteenable = '0;
    err_clr          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_readdata", slave_readdata, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_rd_count", {16'b0, rd_count}, 32'h0);
    check("rst_wr_count", {16'b0, wr_count}, 32'h0);
    check("rst_waitrequest", {31'b0, slave_waitrequest}, 32'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic write/read and byte-enable merge.
    access(0, 1, 32'h10, 32'h1234_5678, 4'hF, 0);
    idle(1);
    check("wr_count_first", {16'b0, wr_count}, 32'd1);
    access(1, 0, 32'h10, 32'h0, 4'h0, 0);
    idle(1);
    check("rd_count_first", {16'b0, rd_count}, 32'd1);
    access(0, 1, 32'h10, 32'hAABB_CCDD, 4'h5, 0);
    idle(1);
    access(1, 0, 32'h13, 32'h0, 4'h0, 0);
    idle(1);

    // Preload words 0..15.
    for (int i = 0; i < 16; i++) begin
      access(0, 1, 32'(i * 4), $urandom, 4'hF, 0);
      idle(0);
    end
    idle(1);

    // Out-of-range write, then clear.
    access(0, 1, 32'h400, 32'hFFFF_FFFF, 4'hF, 0);
    idle(1);
    check("oor_write_err", {31'b0, err}, {31'b0, err_exp});
    check("oor_wr_count", {16'b0, wr_count}, 32'(16'(wr_exp)));
    access(1, 0, 32'h0, 32'h0, 4'h0, 0);
    idle(0);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    err_exp = 1'b0;
    check("err_cleared", {31'b0, err}, 32'h0);

    // Clear and new error in the same cycle: set wins.
    access(1, 0, 32'h0000_0800, 32'h0, 4'h0, 1);
    idle(1);
    check("set_wins", {31'b0, err}, {31'b0, err_exp});
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    err_exp = 1'b0;

    // Read and write together behave as a write and flag an error.
    access(1, 1, 32'h20, 32'hCAFE_F00D, 4'hF, 0);
    idle(1);
    check("both_err", {31'b0, err}, {31'b0, err_exp});
    access(1, 0, 32'h20, 32'h0, 4'h0, 0);
    idle(1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    err_exp = 1'b0;

    // Abort in WAIT.
    slave_address = 32'h8;
    slave_read    = 1'b1;
    @(posedge clk);
    #1;
    slave_read = 1'b0;
    @(posedge clk);
    #1;
    err_exp = 1'b1;
    check("abort_err", {31'b0, err}, 32'h1);
    check("abort_rd_count", {16'b0, rd_count}, 32'(16'(rd_exp)));
    access(1, 0, 32'h8, 32'h0, 4'h0, 0);
    idle(1);

    // Back-to-back read stream.
    for (int i = 0; i < 8; i++) begin
      access(1, 0, 32'(i * 4), 32'h0, 4'h0, 0);
    end
    idle(1);
    check("stream_rd_count", {16'b0, rd_count}, 32'(16'(rd_exp)));

    // Random traffic.
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    err_exp = 1'b0;
    for (int t = 0; t < 80; t++) begin
      int unsigned op;
      logic [31:0] a;
      op = $urandom_range(0, 9);
      a  = {22'b0, 4'($urandom_range(0, 15)), 2'($urandom)};
      if (op >= 8) a = $urandom | 32'h400;
      if (op <= 3 || op == 8) access(0, 1, a, $urandom, 4'($urandom), 0);
      else access(1, 0, a, 32'h0, 4'h0, 0);
      idle($urandom_range(0, 2));
    end
    idle(1);
    check("rand_rd_count", {16'b0, rd_count}, 32'(16'(rd_exp)));
    check("rand_wr_count", {16'b0, wr_count}, 32'(16'(wr_exp)));
    check("rand_err", {31'b0, err}, {31'b0, err_exp});

    // Reset during WAIT of a write.
    slave_address    = 32'h10;
    slave_write      = 1'b1;
    slave_writedata  = 32'hDEAD_BEEF;
    slave_byteenable = 4'hF;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("rstw_wr_count", {16'b0, wr_count}, 32'h0);
    check("rstw_rd_count", {16'b0, rd_count}, 32'h0);
    check("rstw_err", {31'b0, err}, 32'h0);
    check("rstw_readdata", slave_readdata, 32'h0);
    check("rstw_waitrequest", {31'b0, slave_waitrequest}, 32'h1);
    slave_write = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rd_exp  = 0;
    wr_exp  = 0;
    err_exp = 1'b0;
    @(posedge clk);
    #1;
    access(1, 0, 32'h10, 32'h0, 4'h0, 0);
    idle(2);
    check("post_rst_rd_count", {16'b0, rd_count}, 32'd1);
    check("pending_expect", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
